// File: rtl/mx_block_dot_pkg.sv
// ---------------------------------------------------------------------------
// mx_block_dot_pkg
// Shared types and constants for the MX block dot-product datapath.
//   t_vector_datatype : element format selector shared with mx_alu
//   MX_*              : E8M0 scale constants and fixed-point fraction widths
//   MX_EW             : decoded element width (8 for MXINT8 only, 19 with FP8)
// Build option: MX_BLOCK_DOT_FP8_EN enables MXFP8_E4M3 support.
// ---------------------------------------------------------------------------
package mx_block_dot_pkg;

    typedef enum logic [2:0] {
        VDT_INT32      = 3'd0,
        VDT_FP32       = 3'd1,
        VDT_MXINT8     = 3'd2,
        VDT_MXFP8_E4M3 = 3'd3,
        VDT_MXFP8_E5M2 = 3'd4
    } t_vector_datatype;

    localparam int unsigned MX_SCALE_W    = 8;
    localparam int unsigned MX_SCALE_BIAS = 127;
    localparam logic [7:0]  MX_SCALE_NAN  = 8'hFF;
    localparam int unsigned MX_FRAC_INT8  = 12;
    localparam int unsigned MX_FRAC_FP8   = 18;
    localparam int unsigned MX_ELEM_W     = 8;
    localparam int unsigned MX_EXP_W      = 10;

`ifdef MX_BLOCK_DOT_FP8_EN
    localparam int unsigned MX_EW = 19;
`else
    localparam int unsigned MX_EW = 8;
`endif

    // True for element formats this build can accumulate.
    function automatic logic mx_dt_supported(input t_vector_datatype dt);
`ifdef MX_BLOCK_DOT_FP8_EN
        return (dt == VDT_MXINT8) || (dt == VDT_MXFP8_E4M3);
`else
        return (dt == VDT_MXINT8);
`endif
    endfunction

endpackage

// File: rtl/mx_block_dot_elem_decode.sv
// ---------------------------------------------------------------------------
// mx_elem_decode
// Combinational decode of one MX element to signed fixed point.
//   datatype_i  : element format
//   elem_i      : raw 8-bit element
//   value_c_o   : signed MX_EW-bit value (MXINT8: int8, FP8: 2^-9 units)
//   is_nan_c_o  : element is an FP8 NaN (S.1111.111)
// Build option: MX_BLOCK_DOT_FP8_EN adds the MXFP8_E4M3 decode path.
// ---------------------------------------------------------------------------
module mx_elem_decode
    import mx_block_dot_pkg::*;
(
    input  t_vector_datatype        datatype_i,
    input  logic [MX_ELEM_W-1:0]    elem_i,
    output logic signed [MX_EW-1:0] value_c_o,
    output logic                    is_nan_c_o
);

`ifdef MX_BLOCK_DOT_FP8_EN
    logic signed [MX_EW-1:0] mag;
`endif

    // Unsupported formats decode to zero; the top flags them separately.
    always_comb begin
        value_c_o  = '0;
        is_nan_c_o = 1'b0;
`ifdef MX_BLOCK_DOT_FP8_EN
        mag        = '0;
`endif
        case (datatype_i)
            VDT_MXINT8: value_c_o = MX_EW'(signed'(elem_i));
`ifdef MX_BLOCK_DOT_FP8_EN
            VDT_MXFP8_E4M3: begin
                if (elem_i[6:0] == 7'h7F) begin
                    is_nan_c_o = 1'b1;
                end else begin
                    // Subnormals carry the mantissa as-is; normals restore the hidden bit.
                    if (elem_i[6:3] == 4'd0) begin
                        mag = MX_EW'(elem_i[2:0]);
                    end else begin
                        mag = MX_EW'({1'b1, elem_i[2:0]}) << (elem_i[6:3] - 4'd1);
                    end
                    value_c_o = elem_i[7] ? -mag : mag;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mx_block_dot.sv
// ---------------------------------------------------------------------------
// mx_block_dot
// Streaming dot product of two MX vectors sharing a block structure.
// result = out_acc * 2^out_exp.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : beat handshake (LANES elements per operand)
//   in_datatype           : element format, taken from the first beat
//   in_scale_a/b          : E8M0 block scales, taken from the first beat
//   in_elem_a/b           : LANES x 8-bit elements, lane 0 in the LSBs
//   out_valid / out_ready : result handshake
//   out_acc               : signed exact sum of products
//   out_exp               : signed binary exponent of out_acc
//   out_nan               : NaN scale or NaN element seen
//   out_err               : unsupported datatype
// Build option: MX_BLOCK_DOT_FP8_EN enables MXFP8_E4M3.
// ---------------------------------------------------------------------------
module mx_block_dot
    import mx_block_dot_pkg::*;
#(
    parameter  int unsigned BLOCK_SIZE = 32,
    parameter  int unsigned LANES      = 8,
    localparam int unsigned ACC_W      = 2 * MX_EW + $clog2(BLOCK_SIZE) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  t_vector_datatype           in_datatype,
    input  logic [MX_SCALE_W-1:0]      in_scale_a,
    input  logic [MX_SCALE_W-1:0]      in_scale_b,
    input  logic [LANES*MX_ELEM_W-1:0] in_elem_a,
    input  logic [LANES*MX_ELEM_W-1:0] in_elem_b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_acc,
    output logic [MX_EXP_W-1:0]        out_exp,
    output logic                       out_nan,
    output logic                       out_err
);

    localparam int unsigned BEATS  = BLOCK_SIZE / LANES;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PROD_W = 2 * MX_EW;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } t_state;

    t_state                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    t_vector_datatype        dt_q, dt_d;
    logic [MX_SCALE_W-1:0]   sa_q, sa_d, sb_q, sb_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    nan_q, nan_d;
    logic                    out_valid_q, out_valid_d;
    logic [ACC_W-1:0]        out_acc_q, out_acc_d;
    logic [MX_EXP_W-1:0]     out_exp_q, out_exp_d;
    logic                    out_nan_q, out_nan_d;
    logic                    out_err_q, out_err_d;

    logic                    first_beat;
    logic                    last_beat;
    logic                    accept;
    t_vector_datatype        dt_cur;
    logic [MX_SCALE_W-1:0]   sa_cur, sb_cur;
    logic signed [MX_EW-1:0] val_a [LANES];
    logic signed [MX_EW-1:0] val_b [LANES];
    logic [LANES-1:0]        nan_a, nan_b;
    logic signed [ACC_W-1:0] psum;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    nan_sum;
    logic                    res_nan;
    logic [MX_EXP_W-1:0]     frac_cur;
    logic [MX_EXP_W-1:0]     exp_cur;

    // A stalled result blocks new beats; consuming it frees the slot in the same cycle.
    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    // Block attributes come from the live inputs on the first beat, from the latches afterwards.
    assign first_beat = (state_q == ST_IDLE);
    assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));
    assign dt_cur     = first_beat ? in_datatype : dt_q;
    assign sa_cur     = first_beat ? in_scale_a : sa_q;
    assign sb_cur     = first_beat ? in_scale_b : sb_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mx_elem_decode u_dec_a (
            .datatype_i (dt_cur),
            .elem_i     (in_elem_a[l*MX_ELEM_W +: MX_ELEM_W]),
            .value_c_o  (val_a[l]),
            .is_nan_c_o (nan_a[l])
        );
        mx_elem_decode u_dec_b (
            .datatype_i (dt_cur),
            .elem_i     (in_elem_b[l*MX_ELEM_W +: MX_ELEM_W]),
            .value_c_o  (val_b[l]),
            .is_nan_c_o (nan_b[l])
        );
    end

    // Per-beat sum of LANES exact products.
    always_comb begin
        psum = '0;
        for (int l = 0; l < LANES; l++) begin
            psum = psum + ACC_W'(PROD_W'(val_a[l]) * PROD_W'(val_b[l]));
        end
    end

    assign acc_sum  = first_beat ? psum : acc_q + psum;
    assign nan_sum  = (!first_beat && nan_q) || (|nan_a) || (|nan_b);
    assign res_nan  = nan_sum || (sa_cur == MX_SCALE_NAN) || (sb_cur == MX_SCALE_NAN);
    assign frac_cur = (dt_cur == VDT_MXFP8_E4M3) ? MX_EXP_W'(MX_FRAC_FP8) : MX_EXP_W'(MX_FRAC_INT8);
    assign exp_cur  = MX_EXP_W'(sa_cur) + MX_EXP_W'(sb_cur)
                    - MX_EXP_W'(2 * MX_SCALE_BIAS) - frac_cur;

    // Next-state and result logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dt_d        = dt_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        acc_d       = acc_q;
        nan_d       = nan_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_exp_d   = out_exp_q;
        out_nan_d   = out_nan_q;
        out_err_d   = out_err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (first_beat) begin
                dt_d = in_datatype;
                sa_d = in_scale_a;
                sb_d = in_scale_b;
            end
            acc_d = acc_sum;
            nan_d = nan_sum;
            if (last_beat) begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                out_valid_d = 1'b1;
                if (!mx_dt_supported(dt_cur)) begin
                    out_err_d = 1'b1;
                    out_nan_d = 1'b0;
                    out_acc_d = '0;
                    out_exp_d = '0;
                end else begin
                    out_err_d = 1'b0;
                    out_nan_d = res_nan;
                    out_acc_d = res_nan ? '0 : acc_sum;
                    out_exp_d = exp_cur;
                end
            end else begin
                state_d = ST_ACCUM;
                cnt_d   = cnt_q + CNT_W'(1);
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dt_q        <= VDT_INT32;
            sa_q        <= '0;
            sb_q        <= '0;
            acc_q       <= '0;
            nan_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_exp_q   <= '0;
            out_nan_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dt_q        <= dt_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            acc_q       <= acc_d;
            nan_q       <= nan_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_exp_q   <= out_exp_d;
            out_nan_q   <= out_nan_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_exp   = out_exp_q;
    assign out_nan   = out_nan_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_mx_block_dot.sv
// ---------------------------------------------------------------------------
// tb_mx_block_dot
// Directed bench for mx_block_dot with hand-computed expected results.
// Build option: MX_BLOCK_DOT_FP8_EN selects the FP8 expectations.
// ---------------------------------------------------------------------------
module tb_mx_block_dot;
    import mx_block_dot_pkg::*;

    localparam int unsigned BLOCK_SIZE = 32;
    localparam int unsigned LANES      = 8;
    localparam int unsigned BEATS      = BLOCK_SIZE / LANES;
    localparam int unsigned ACC_W      = 2 * MX_EW + $clog2(BLOCK_SIZE) + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    t_vector_datatype     in_datatype = VDT_MXINT8;
    logic [7:0]           in_scale_a = 8'd0;
    logic [7:0]           in_scale_b = 8'd0;
    logic [LANES*8-1:0]   in_elem_a = '0;
    logic [LANES*8-1:0]   in_elem_b = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [ACC_W-1:0]     out_acc;
    logic [MX_EXP_W-1:0]  out_exp;
    logic                 out_nan;
    logic                 out_err;

    logic [7:0] a_blk [BLOCK_SIZE];
    logic [7:0] b_blk [BLOCK_SIZE];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   wait_cnt;
    logic stable;

    mx_block_dot #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .LANES      (LANES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_datatype (in_datatype),
        .in_scale_a  (in_scale_a),
        .in_scale_b  (in_scale_b),
        .in_elem_a   (in_elem_a),
        .in_elem_b   (in_elem_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_exp     (out_exp),
        .out_nan     (out_nan),
        .out_err     (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint acc_s();
        return longint'($signed(out_acc));
    endfunction

    function automatic longint exp_s();
        return longint'($signed(out_exp));
    endfunction

    task automatic fill_uniform(input logic [7:0] a, input logic [7:0] b);
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            a_blk[k] = a;
            b_blk[k] = b;
        end
    endtask

    // Later beats carry a wrong datatype and scale 127 to show they are ignored.
    task automatic send_block(input t_vector_datatype dt, input logic [7:0] sa,
                              input logic [7:0] sb, input int n_beats);
        int b = 0;
        int guard = 0;
        while (b < n_beats && guard < 200) begin
            @(negedge clk);
            in_valid    = 1'b1;
            in_datatype = (b == 0) ? dt : VDT_FP32;
            in_scale_a  = (b == 0) ? sa : 8'd127;
            in_scale_b  = (b == 0) ? sb : 8'd127;
            for (int l = 0; l < LANES; l++) begin
                in_elem_a[l*8 +: 8] = a_blk[b*LANES + l];
                in_elem_b[l*8 +: 8] = b_blk[b*LANES + l];
            end
            #1;
            if (in_ready) b++;
            guard++;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (b < n_beats) check("send_timeout", longint'(b), longint'(n_beats));
    endtask

    // Sampled on the first falling edge after the last beat is accepted.
    task automatic expect_result(input string tag, input longint acc, input longint ex,
                                 input logic nan, input logic err);
        @(negedge clk);
        check({tag, "_valid"}, longint'(out_valid), 1);
        check({tag, "_acc"}, acc_s(), acc);
        check({tag, "_exp"}, exp_s(), ex);
        check({tag, "_nan"}, longint'(out_nan), longint'(nan));
        check({tag, "_err"}, longint'(out_err), longint'(err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", longint'(in_ready), 1);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_acc", acc_s(), 0);
        check("rst_out_exp", exp_s(), 0);
        check("rst_out_nan", longint'(out_nan), 0);
        check("rst_out_err", longint'(out_err), 0);

        // 64*64*32 = 131072, exponent 0+0-12
        fill_uniform(8'h40, 8'h40);
        send_block(VDT_MXINT8, 8'd127, 8'd127, BEATS);
        expect_result("int8_pos", 131072, -12, 1'b0, 1'b0);
        @(negedge clk);
        check("int8_pos_consumed", longint'(out_valid), 0);

        // -128*127*32 = -520192, exponent 3-2-12
        fill_uniform(8'h80, 8'h7F);
        send_block(VDT_MXINT8, 8'd130, 8'd125, BEATS);
        expect_result("int8_neg", -520192, -11, 1'b0, 1'b0);

        // a[k] = k-16, b = 3: sum(k-16) = -16, times 3
        for (int k = 0; k < BLOCK_SIZE; k++) begin
            a_blk[k] = 8'(k - 16);
            b_blk[k] = 8'd3;
        end
        send_block(VDT_MXINT8, 8'd127, 8'd127, BEATS);
        expect_result("int8_ramp", -48, -12, 1'b0, 1'b0);

        // NaN scale on the first beat only; exponent 128+0-12
        fill_uniform(8'h40, 8'h40);
        send_block(VDT_MXINT8, 8'hFF, 8'd127, BEATS);
        expect_result("nan_scale", 0, 116, 1'b1, 1'b0);

        send_block(VDT_MXFP8_E5M2, 8'd127, 8'd127, BEATS);
        expect_result("unsupported", 0, 0, 1'b0, 1'b1);

        // FP8 0x38 = 1.0 = 512 in 2^-9 units: 512*512*32 = 2^23
        fill_uniform(8'h38, 8'h38);
        send_block(VDT_MXFP8_E4M3, 8'd127, 8'd127, BEATS);
`ifdef MX_BLOCK_DOT_FP8_EN
        expect_result("fp8_one", 64'sd8388608, -18, 1'b0, 1'b0);
`else
        expect_result("fp8_off", 0, 0, 1'b0, 1'b1);
`endif

        // Two back-to-back blocks under a stalled consumer
        @(negedge clk);
        out_ready = 1'b0;
        fork
            begin
                fill_uniform(8'h40, 8'h40);
                send_block(VDT_MXINT8, 8'd127, 8'd127, BEATS);
                fill_uniform(8'h02, 8'h03);
                send_block(VDT_MXINT8, 8'd127, 8'd127, BEATS);
            end
            begin
                wait_cnt = 0;
                while (!out_valid && wait_cnt < 100) begin
                    @(negedge clk);
                    wait_cnt++;
                end
                check("bp_a_valid", longint'(out_valid), 1);
                check("bp_a_acc", acc_s(), 131072);
                #1 check("bp_in_ready_low", longint'(in_ready), 0);
                stable = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    if (!(out_valid && acc_s() == 131072)) stable = 1'b0;
                end
                check("bp_hold", longint'(stable), 1);
                @(negedge clk);
                out_ready = 1'b1;
                @(negedge clk);
                check("bp_a_consumed", longint'(out_valid), 0);
                wait_cnt = 0;
                while (!out_valid && wait_cnt < 100) begin
                    @(negedge clk);
                    wait_cnt++;
                end
                check("bp_b_valid", longint'(out_valid), 1);
                check("bp_b_acc", acc_s(), 192);
            end
        join

        // Reset after two beats drops the partial block
        fill_uniform(8'h7F, 8'h7F);
        send_block(VDT_MXINT8, 8'd127, 8'd127, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", longint'(out_valid), 0);
        fill_uniform(8'h40, 8'h40);
        send_block(VDT_MXINT8, 8'd127, 8'd127, BEATS);
        expect_result("midrst", 131072, -12, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
